// File: rtl/rob_commit_ctrl_pkg.sv
// Shared widths and defaults for the reorder-buffer commit controller.
package rob_commit_ctrl_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_TAG_W = 4;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rob_entry_array.sv
// Per-entry ROB storage: allocation and CDB write ports, head read port and
// two operand-forwarding read ports.
module rob_entry_array
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned XLEN  = DEF_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_all,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  logic             alloc_has_rd,
  input  reg_idx_t         alloc_rd,
  input  logic             cdb_valid,
  input  logic             cdb_write_en,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic             retire_en,
  input  logic [TAG_W-1:0] head_idx,
  output logic             head_busy,
  output logic             head_done,
  output logic             head_has_rd,
  output reg_idx_t         head_rd,
  output logic [XLEN-1:0]  head_val,
  input  logic [TAG_W-1:0] qry_tag1,
  input  logic [TAG_W-1:0] qry_tag2,
  output logic             qry_ready1,
  output logic             qry_ready2,
  output logic [XLEN-1:0]  qry_val1,
  output logic [XLEN-1:0]  qry_val2
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] has_rd_q;
  reg_idx_t         rd_q  [DEPTH];
  logic [XLEN-1:0]  val_q [DEPTH];

  // Results for squashed or already-retired tags are dropped.
  logic cdb_hit;
  assign cdb_hit = cdb_write_en & cdb_valid & busy_q[cdb_tag];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      done_q   <= '0;
      has_rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else if (clear_all) begin
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_en && alloc_idx == TAG_W'(i)) begin
          busy_q[i]   <= 1'b1;
          done_q[i]   <= 1'b0;
          has_rd_q[i] <= alloc_has_rd;
          rd_q[i]     <= alloc_rd;
        end else if (cdb_hit && cdb_tag == TAG_W'(i)) begin
          done_q[i] <= 1'b1;
          val_q[i]  <= cdb_val;
        end
        if (retire_en && head_idx == TAG_W'(i)) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b0;
        end
      end
    end
  end

  assign head_busy   = busy_q[head_idx];
  assign head_done   = done_q[head_idx];
  assign head_has_rd = has_rd_q[head_idx];
  assign head_rd     = rd_q[head_idx];
  assign head_val    = val_q[head_idx];

  // A same-cycle CDB broadcast wins over the stored copy.
  always_comb begin
    qry_ready1 = 1'b0;
    qry_val1   = '0;
    if (cdb_valid && cdb_tag == qry_tag1 && busy_q[qry_tag1]) begin
      qry_ready1 = 1'b1;
      qry_val1   = cdb_val;
    end else if (busy_q[qry_tag1] && done_q[qry_tag1]) begin
      qry_ready1 = 1'b1;
      qry_val1   = val_q[qry_tag1];
    end
    qry_ready2 = 1'b0;
    qry_val2   = '0;
    if (cdb_valid && cdb_tag == qry_tag2 && busy_q[qry_tag2]) begin
      qry_ready2 = 1'b1;
      qry_val2   = cdb_val;
    end else if (busy_q[qry_tag2] && done_q[qry_tag2]) begin
      qry_ready2 = 1'b1;
      qry_val2   = val_q[qry_tag2];
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: allocates tags, captures CDB results and retires
// entries in order into the rename register file.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned XLEN  = DEF_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic             issue_has_rd,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic [TAG_W-1:0] qry_tag1,
  input  logic [TAG_W-1:0] qry_tag2,
  output logic             qry_ready1,
  output logic             qry_ready2,
  output logic [XLEN-1:0]  qry_val1,
  output logic [XLEN-1:0]  qry_val2,
  input  logic             flush,
  output logic             rf_rd_in_flag,
  output logic [4:0]       rf_rd_in_a,
  output logic [TAG_W-1:0] rf_rd_in_rob,
  output logic             rf_rd_out_flag,
  output logic [4:0]       rf_rd_out_a,
  output logic [XLEN-1:0]  rf_rd_out_val,
  output logic [TAG_W-1:0] rf_rd_out_rob,
  output logic             rf_flush,
  output logic [TAG_W:0]   count
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             accept, commit, clear_all;
  logic             head_busy, head_done, head_has_rd;
  reg_idx_t         head_rd;
  logic [XLEN-1:0]  head_val;

  assign clear_all   = rdy & flush;
  // Uses the pre-commit count: a slot freed this cycle is not reusable yet.
  assign issue_ready = rdy & ~flush & (count_q != (TAG_W+1)'(DEPTH));
  assign accept      = issue_valid & issue_ready;
  assign commit      = rdy & ~flush & head_busy & head_done;

  assign issue_tag     = tail_q;
  assign rf_rd_in_flag = accept & issue_has_rd & (issue_rd != '0);
  assign rf_rd_in_a    = issue_rd;
  assign rf_rd_in_rob  = tail_q;

  assign rf_rd_out_flag = commit & head_has_rd & (head_rd != '0);
  assign rf_rd_out_a    = head_rd;
  assign rf_rd_out_val  = head_val;
  assign rf_rd_out_rob  = head_q;

  assign rf_flush = clear_all;
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_all) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) tail_d = tail_q + 1'b1;
      if (commit) head_d = head_q + 1'b1;
      count_d = count_q + (TAG_W+1)'(accept) - (TAG_W+1)'(commit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  rob_entry_array #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .XLEN (XLEN)
  ) u_entries (
    .clk         (clk),
    .rst         (rst),
    .clear_all   (clear_all),
    .alloc_en    (accept),
    .alloc_idx   (tail_q),
    .alloc_has_rd(issue_has_rd),
    .alloc_rd    (issue_rd),
    .cdb_valid   (cdb_valid),
    .cdb_write_en(rdy & ~flush),
    .cdb_tag     (cdb_tag),
    .cdb_val     (cdb_val),
    .retire_en   (commit),
    .head_idx    (head_q),
    .head_busy   (head_busy),
    .head_done   (head_done),
    .head_has_rd (head_has_rd),
    .head_rd     (head_rd),
    .head_val    (head_val),
    .qry_tag1    (qry_tag1),
    .qry_tag2    (qry_tag2),
    .qry_ready1  (qry_ready1),
    .qry_ready2  (qry_ready2),
    .qry_val1    (qry_val1),
    .qry_val2    (qry_val2)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: rename, CDB capture, in-order commit,
// full/wrap, forwarding, flush, clock-enable freeze and async reset.
module tb_rob_commit_ctrl;

  logic        clk, rst, rdy;
  logic        issue_valid, issue_has_rd;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [3:0]  qry_tag1, qry_tag2;
  logic        qry_ready1, qry_ready2;
  logic [31:0] qry_val1, qry_val2;
  logic        flush;
  logic        rf_rd_in_flag;
  logic [4:0]  rf_rd_in_a;
  logic [3:0]  rf_rd_in_rob;
  logic        rf_rd_out_flag;
  logic [4:0]  rf_rd_out_a;
  logic [31:0] rf_rd_out_val;
  logic [3:0]  rf_rd_out_rob;
  logic        rf_flush;
  logic [4:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  rob_commit_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .issue_valid   (issue_valid),
    .issue_has_rd  (issue_has_rd),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .issue_tag     (issue_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_val       (cdb_val),
    .qry_tag1      (qry_tag1),
    .qry_tag2      (qry_tag2),
    .qry_ready1    (qry_ready1),
    .qry_ready2    (qry_ready2),
    .qry_val1      (qry_val1),
    .qry_val2      (qry_val2),
    .flush         (flush),
    .rf_rd_in_flag (rf_rd_in_flag),
    .rf_rd_in_a    (rf_rd_in_a),
    .rf_rd_in_rob  (rf_rd_in_rob),
    .rf_rd_out_flag(rf_rd_out_flag),
    .rf_rd_out_a   (rf_rd_out_a),
    .rf_rd_out_val (rf_rd_out_val),
    .rf_rd_out_rob (rf_rd_out_rob),
    .rf_flush      (rf_flush),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
    qry_tag1 = '0; qry_tag2 = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    total_cnt++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready got %0b exp 1", issue_ready); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (issue_tag !== 4'd0) $display("FAIL reset_issue_tag got %0d exp 0", issue_tag); else pass_cnt++;
    total_cnt++; if (rf_rd_out_flag !== 1'b0 || rf_rd_out_val !== 32'd0 || rf_rd_out_a !== 5'd0)
      $display("FAIL reset_rd_out got flag=%0b a=%0d val=%h exp 0/0/0", rf_rd_out_flag, rf_rd_out_a, rf_rd_out_val);
    else pass_cnt++;
    total_cnt++; if (qry_ready1 !== 1'b0 || rf_flush !== 1'b0 || rf_rd_in_flag !== 1'b0)
      $display("FAIL reset_misc got qry=%0b flush=%0b in=%0b exp 0/0/0", qry_ready1, rf_flush, rf_rd_in_flag);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd5;
    #1;
    total_cnt++; if (issue_tag !== 4'd0) $display("FAIL single_tag got %0d exp 0", issue_tag); else pass_cnt++;
    total_cnt++; if (rf_rd_in_flag !== 1'b1 || rf_rd_in_a !== 5'd5 || rf_rd_in_rob !== 4'd0)
      $display("FAIL single_rename got flag=%0b a=%0d rob=%0d exp 1/5/0", rf_rd_in_flag, rf_rd_in_a, rf_rd_in_rob);
    else pass_cnt++;
    step();
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h1234;
    #1;
    total_cnt++; if (count !== 5'd1) $display("FAIL single_count1 got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (rf_rd_out_flag !== 1'b0) $display("FAIL single_early_commit got %0b exp 0", rf_rd_out_flag); else pass_cnt++;
    step();
    cdb_valid = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || rf_rd_out_a !== 5'd5 || rf_rd_out_val !== 32'h1234 || rf_rd_out_rob !== 4'd0)
      $display("FAIL single_commit got flag=%0b a=%0d val=%h rob=%0d exp 1/5/00001234/0",
               rf_rd_out_flag, rf_rd_out_a, rf_rd_out_val, rf_rd_out_rob);
    else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd0) $display("FAIL single_count0 got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_rd_zero();
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd0;
    #1;
    total_cnt++; if (issue_tag !== 4'd1 || rf_rd_in_flag !== 1'b0)
      $display("FAIL rd0_rename got tag=%0d flag=%0b exp 1/0", issue_tag, rf_rd_in_flag);
    else pass_cnt++;
    step();
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h55;
    step();
    cdb_valid = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b0 || rf_rd_out_rob !== 4'd1 || count !== 5'd1)
      $display("FAIL rd0_commit got flag=%0b rob=%0d count=%0d exp 0/1/1", rf_rd_out_flag, rf_rd_out_rob, count);
    else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd0 || issue_tag !== 4'd2 || rf_rd_out_rob !== 4'd2)
      $display("FAIL rd0_advance got count=%0d tail=%0d head=%0d exp 0/2/2", count, issue_tag, rf_rd_out_rob);
    else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue_has_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(10 + i);
      #1;
      total_cnt++; if (issue_tag !== 4'(i)) $display("FAIL ooo_tag%0d got %0d exp %0d", i, issue_tag, i); else pass_cnt++;
      step();
    end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h22;
    step();
    cdb_tag = 4'd1; cdb_val = 32'h11;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b0) $display("FAIL ooo_no_commit got %0b exp 0", rf_rd_out_flag); else pass_cnt++;
    step();
    cdb_tag = 4'd0; cdb_val = 32'h10;
    step();
    cdb_valid = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || rf_rd_out_rob !== 4'd0 || rf_rd_out_val !== 32'h10 || rf_rd_out_a !== 5'd10)
      $display("FAIL ooo_commit0 got flag=%0b rob=%0d val=%h a=%0d exp 1/0/10/10", rf_rd_out_flag, rf_rd_out_rob, rf_rd_out_val, rf_rd_out_a);
    else pass_cnt++;
    step();
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || rf_rd_out_rob !== 4'd1 || rf_rd_out_val !== 32'h11 || rf_rd_out_a !== 5'd11)
      $display("FAIL ooo_commit1 got flag=%0b rob=%0d val=%h a=%0d exp 1/1/11/11", rf_rd_out_flag, rf_rd_out_rob, rf_rd_out_val, rf_rd_out_a);
    else pass_cnt++;
    step();
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || rf_rd_out_rob !== 4'd2 || rf_rd_out_val !== 32'h22 || rf_rd_out_a !== 5'd12)
      $display("FAIL ooo_commit2 got flag=%0b rob=%0d val=%h a=%0d exp 1/2/22/12", rf_rd_out_flag, rf_rd_out_rob, rf_rd_out_val, rf_rd_out_a);
    else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd0) $display("FAIL ooo_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_has_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      step();
    end
    // Issue held with rd=7 while the head completes.
    issue_rd = 5'd7; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h77;
    #1;
    total_cnt++; if (count !== 5'd16 || issue_ready !== 1'b0)
      $display("FAIL full_state got count=%0d ready=%0b exp 16/0", count, issue_ready);
    else pass_cnt++;
    step();
    cdb_valid = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || issue_ready !== 1'b0 || rf_rd_in_flag !== 1'b0)
      $display("FAIL full_commit_cycle got out=%0b ready=%0b in=%0b exp 1/0/0", rf_rd_out_flag, issue_ready, rf_rd_in_flag);
    else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd15 || issue_ready !== 1'b1 || issue_tag !== 4'd0)
      $display("FAIL full_reopen got count=%0d ready=%0b tag=%0d exp 15/1/0", count, issue_ready, issue_tag);
    else pass_cnt++;
    total_cnt++; if (rf_rd_in_flag !== 1'b1 || rf_rd_in_rob !== 4'd0 || rf_rd_in_a !== 5'd7)
      $display("FAIL wrap_rename got flag=%0b rob=%0d a=%0d exp 1/0/7", rf_rd_in_flag, rf_rd_in_rob, rf_rd_in_a);
    else pass_cnt++;
    step();
    issue_valid = 1'b0;
    #1;
    total_cnt++; if (count !== 5'd16 || issue_ready !== 1'b0 || rf_rd_out_rob !== 4'd1)
      $display("FAIL wrap_full got count=%0d ready=%0b head=%0d exp 16/0/1", count, issue_ready, rf_rd_out_rob);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    qry_tag1 = 4'd3; qry_tag2 = 4'd4;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hAA;
    #1;
    total_cnt++; if (qry_ready1 !== 1'b1 || qry_val1 !== 32'hAA)
      $display("FAIL fwd_bypass got ready=%0b val=%h exp 1/000000aa", qry_ready1, qry_val1);
    else pass_cnt++;
    total_cnt++; if (qry_ready2 !== 1'b0 || qry_val2 !== 32'd0)
      $display("FAIL fwd_pending got ready=%0b val=%h exp 0/0", qry_ready2, qry_val2);
    else pass_cnt++;
    step();
    cdb_valid = 1'b0; qry_tag2 = 4'd3;
    #1;
    total_cnt++; if (qry_ready2 !== 1'b1 || qry_val2 !== 32'hAA)
      $display("FAIL fwd_stored got ready=%0b val=%h exp 1/000000aa", qry_ready2, qry_val2);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    issue_has_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      step();
    end
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h5;
    step();
    cdb_valid = 1'b0;
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9; qry_tag1 = 4'd0;
    #1;
    total_cnt++; if (rf_flush !== 1'b1 || rf_rd_in_flag !== 1'b0 || issue_ready !== 1'b0 || rf_rd_out_flag !== 1'b0)
      $display("FAIL flush_cycle got rf_flush=%0b in=%0b ready=%0b out=%0b exp 1/0/0/0",
               rf_flush, rf_rd_in_flag, issue_ready, rf_rd_out_flag);
    else pass_cnt++;
    step();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    total_cnt++; if (count !== 5'd0 || issue_tag !== 4'd0 || qry_ready1 !== 1'b0 || rf_rd_out_rob !== 4'd0)
      $display("FAIL flush_after got count=%0d tail=%0d qry=%0b head=%0d exp 0/0/0/0",
               count, issue_tag, qry_ready1, rf_rd_out_rob);
    else pass_cnt++;
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0; flush = 1'b1; issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
    #1;
    total_cnt++; if (issue_ready !== 1'b0 || rf_rd_in_flag !== 1'b0 || rf_flush !== 1'b0)
      $display("FAIL freeze_outputs got ready=%0b in=%0b flush=%0b exp 0/0/0", issue_ready, rf_rd_in_flag, rf_flush);
    else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd0) $display("FAIL freeze_count got %0d exp 0", count); else pass_cnt++;
    rdy = 1'b1; flush = 1'b0;
    step();
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'hBEEF;
    step();
    cdb_valid = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b1 || rf_rd_out_val !== 32'hBEEF || rf_rd_out_a !== 5'd3)
      $display("FAIL freeze_resume got flag=%0b val=%h a=%0d exp 1/0000beef/3", rf_rd_out_flag, rf_rd_out_val, rf_rd_out_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (rf_rd_out_flag !== 1'b0 || count !== 5'd0 || rf_rd_out_val !== 32'd0 || rf_rd_out_a !== 5'd0)
      $display("FAIL midreset got flag=%0b count=%0d val=%h a=%0d exp 0/0/0/0",
               rf_rd_out_flag, count, rf_rd_out_val, rf_rd_out_a);
    else pass_cnt++;
    total_cnt++; if (issue_ready !== 1'b1 || issue_tag !== 4'd0)
      $display("FAIL midreset_issue got ready=%0b tag=%0d exp 1/0", issue_ready, issue_tag);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    step();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    test_reset();
    test_single();
    test_rd_zero();
    test_out_of_order();
    test_full_wrap();
    test_forward();
    test_flush();
    test_rdy_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
